// File: rtl/block_nest_checker.sv
// rtl/block_nest_checker.sv - streaming begin/end nesting checker over an ASCII byte stream
//
// Purpose:
//   Consumes one ASCII byte per cycle when in_valid is high and splits the
//   stream into words, which are maximal runs of letters. The words "begin"
//   and "end" are committed when the separator that follows them arrives.
//   The block tracks nesting depth, a high-water mark and sticky
//   underflow/overflow errors. The combinational 'result' verdict treats the
//   word currently in progress as if it had already been terminated.
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-low reset (0 = reset)
//   in_valid   in   1        the byte on 'in' is consumed this cycle when 1
//   in         in   8        ASCII byte
//   result     out  1        1 = stream so far is balanced and error-free
//   depth      out  DEPTH_W  committed nesting depth
//   max_depth  out  DEPTH_W  high-water mark of depth since reset
//   err_under  out  1        sticky: 'end' committed at depth 0
//   err_over   out  1        sticky: 'begin' committed at maximum depth

module block_nest_checker #(
    parameter int DEPTH_W   = 8,
    parameter bit CASE_SENS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic [DEPTH_W-1:0] max_depth,
    output logic               err_under,
    output logic               err_over
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_B1,
        S_B2,
        S_B3,
        S_B4,
        S_B5,
        S_E1,
        S_E2,
        S_E3,
        S_OTHER
    } state_t;

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DEPTH_W-1:0] max_depth_q, max_depth_d;
    logic               err_under_q, err_under_d;
    logic               err_over_q, err_over_d;

    logic       is_upper;
    logic       is_lower;
    logic       is_letter;
    logic [7:0] ch;
    logic       commit_begin;
    logic       commit_end;

    // Letter classification uses the raw byte; only the keyword compare sees
    // the folded byte. In case-sensitive mode an uppercase letter is still a
    // letter, so it extends the word but never matches a keyword character.
    assign is_upper  = (in >= 8'h41) && (in <= 8'h5A);
    assign is_lower  = (in >= 8'h61) && (in <= 8'h7A);
    assign is_letter = is_upper || is_lower;
    assign ch        = (!CASE_SENS && is_upper) ? (in | 8'h20) : in;

    assign commit_begin = in_valid && (state_q == S_B5) && !is_letter;
    assign commit_end   = in_valid && (state_q == S_E3) && !is_letter;

    // State register and registered counters/flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            depth_q     <= '0;
            max_depth_q <= '0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            max_depth_q <= max_depth_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end

    // Word FSM next state
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            if (!is_letter) begin
                state_d = S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ch == 8'h62)      state_d = S_B1;
                        else if (ch == 8'h65) state_d = S_E1;
                        else                  state_d = S_OTHER;
                    end
                    S_B1:    state_d = (ch == 8'h65) ? S_B2 : S_OTHER;
                    S_B2:    state_d = (ch == 8'h67) ? S_B3 : S_OTHER;
                    S_B3:    state_d = (ch == 8'h69) ? S_B4 : S_OTHER;
                    S_B4:    state_d = (ch == 8'h6E) ? S_B5 : S_OTHER;
                    S_E1:    state_d = (ch == 8'h6E) ? S_E2 : S_OTHER;
                    S_E2:    state_d = (ch == 8'h64) ? S_E3 : S_OTHER;
                    default: state_d = S_OTHER;
                endcase
            end
        end
    end

    // Depth tracking: saturating at both ends, saturation reported via flags
    always_comb begin
        depth_d     = depth_q;
        max_depth_d = max_depth_q;
        err_under_d = err_under_q;
        err_over_d  = err_over_q;
        if (commit_begin) begin
            if (depth_q == DEPTH_MAX) begin
                err_over_d = 1'b1;
            end else begin
                depth_d = depth_q + DEPTH_ONE;
                // The high-water mark only ever follows an increment, so
                // comparing the new depth against it is sufficient.
                if ((depth_q + DEPTH_ONE) > max_depth_q) begin
                    max_depth_d = depth_q + DEPTH_ONE;
                end
            end
        end else if (commit_end) begin
            if (depth_q == '0) begin
                err_under_d = 1'b1;
            end else begin
                depth_d = depth_q - DEPTH_ONE;
            end
        end
    end

    // Verdict: the word in progress is treated as already terminated.
    // A pending 'begin' always leaves the stream open; a pending 'end'
    // balances only if it closes the last open level.
    always_comb begin
        result = 1'b0;
        if (err_under_q || err_over_q) begin
            result = 1'b0;
        end else if (state_q == S_B5) begin
            result = 1'b0;
        end else if (state_q == S_E3) begin
            result = (depth_q == DEPTH_ONE);
        end else begin
            result = (depth_q == '0);
        end
    end

    assign depth     = depth_q;
    assign max_depth = max_depth_q;
    assign err_under = err_under_q;
    assign err_over  = err_over_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// tb/tb_block_nest_checker.sv - scoreboard bench for block_nest_checker

module tb_block_nest_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in;

    // dut_a: defaults; dut_c: case-sensitive; dut_w: 2-bit depth
    logic       a_result, a_eu, a_eo;
    logic [7:0] a_depth, a_max;
    logic       c_result, c_eu, c_eo;
    logic [7:0] c_depth, c_max;
    logic       w_result, w_eu, w_eo;
    logic [1:0] w_depth, w_max;

    block_nest_checker dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .result(a_result), .depth(a_depth), .max_depth(a_max),
        .err_under(a_eu), .err_over(a_eo)
    );

    block_nest_checker #(.DEPTH_W(8), .CASE_SENS(1'b1)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .result(c_result), .depth(c_depth), .max_depth(c_max),
        .err_under(c_eu), .err_over(c_eo)
    );

    block_nest_checker #(.DEPTH_W(2), .CASE_SENS(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
        .result(w_result), .depth(w_depth), .max_depth(w_max),
        .err_under(w_eu), .err_over(w_eo)
    );

    always #5 clk = ~clk;

    localparam int F_RES = 0;
    localparam int F_DEP = 1;
    localparam int F_MAX = 2;
    localparam int F_EU  = 3;
    localparam int F_EO  = 4;

    typedef struct {
        string name;
        int    sel;
        int    fld;
        int    exp;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int actual(input int sel, input int fld);
        int v;
        v = -1;
        case (sel)
            0: case (fld)
                F_RES: v = int'(a_result);
                F_DEP: v = int'(a_depth);
                F_MAX: v = int'(a_max);
                F_EU:  v = int'(a_eu);
                default: v = int'(a_eo);
            endcase
            1: case (fld)
                F_RES: v = int'(c_result);
                F_DEP: v = int'(c_depth);
                F_MAX: v = int'(c_max);
                F_EU:  v = int'(c_eu);
                default: v = int'(c_eo);
            endcase
            default: case (fld)
                F_RES: v = int'(w_result);
                F_DEP: v = int'(w_depth);
                F_MAX: v = int'(w_max);
                F_EU:  v = int'(w_eu);
                default: v = int'(w_eo);
            endcase
        endcase
        return v;
    endfunction

    // Monitor: drains pending expectations on the falling edge, where the
    // registered outputs are stable.
    always @(negedge clk) begin
        chk_t c;
        int   act;
        while (q.size() > 0) begin
            c   = q.pop_front();
            act = actual(c.sel, c.fld);
            total++;
            if (act != c.exp) begin
                bad++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input int fld, input int exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.fld  = fld;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic flush();
        int n;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL flush_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in       = 8'h20;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state
        expect_val("rst_result_a", 0, F_RES, 1);
        expect_val("rst_depth_a",  0, F_DEP, 0);
        expect_val("rst_max_a",    0, F_MAX, 0);
        expect_val("rst_eu_a",     0, F_EU,  0);
        expect_val("rst_eo_a",     0, F_EO,  0);
        expect_val("rst_result_w", 2, F_RES, 1);
        flush();

        // T1: "begin end "
        send_str("begin");
        expect_val("t1_b5_result", 0, F_RES, 0);
        expect_val("t1_b5_depth",  0, F_DEP, 0);
        flush();
        send_str(" ");
        expect_val("t1_depth1", 0, F_DEP, 1);
        expect_val("t1_max1",   0, F_MAX, 1);
        expect_val("t1_open_result", 0, F_RES, 0);
        flush();
        send_str("end");
        expect_val("t1_e3_result", 0, F_RES, 1);
        expect_val("t1_e3_depth",  0, F_DEP, 1);
        flush();
        send_str(" ");
        expect_val("t1_final_depth",  0, F_DEP, 0);
        expect_val("t1_final_result", 0, F_RES, 1);
        expect_val("t1_max_holds",    0, F_MAX, 1);
        flush();

        // T2: "end begin "
        do_reset();
        send_str("end ");
        expect_val("t2_eu",     0, F_EU,  1);
        expect_val("t2_depth0", 0, F_DEP, 0);
        expect_val("t2_result", 0, F_RES, 0);
        flush();
        send_str("begin ");
        expect_val("t2_depth1",   0, F_DEP, 1);
        expect_val("t2_eu_stick", 0, F_EU,  1);
        expect_val("t2_result_end", 0, F_RES, 0);
        flush();
        do_reset();
        expect_val("t2_rst_result", 0, F_RES, 1);
        expect_val("t2_rst_eu",     0, F_EU,  0);
        expect_val("t2_rst_depth",  0, F_DEP, 0);
        expect_val("t2_rst_max",    0, F_MAX, 0);
        flush();

        // T3: "Begin bEgInx END"
        do_reset();
        send_str("Begin bEgInx ");
        expect_val("t3_ci_depth",  0, F_DEP, 1);
        expect_val("t3_cs_depth",  1, F_DEP, 0);
        flush();
        send_str("END");
        expect_val("t3_ci_result", 0, F_RES, 1);
        expect_val("t3_ci_depth_pending", 0, F_DEP, 1);
        expect_val("t3_cs_result", 1, F_RES, 1);
        expect_val("t3_cs_depth_end", 1, F_DEP, 0);
        expect_val("t3_cs_eu", 1, F_EU, 0);
        flush();
        send_str(" ");
        expect_val("t3_ci_committed", 0, F_DEP, 0);
        flush();

        // T4: "begin " x4 on the 2-bit instance
        do_reset();
        for (int i = 0; i < 3; i++) send_str("begin ");
        expect_val("t4_depth3",  2, F_DEP, 3);
        expect_val("t4_eo_pre",  2, F_EO,  0);
        flush();
        send_str("begin ");
        expect_val("t4_depth_sat", 2, F_DEP, 3);
        expect_val("t4_eo",        2, F_EO,  1);
        expect_val("t4_max",       2, F_MAX, 3);
        expect_val("t4_result",    2, F_RES, 0);
        expect_val("t4_wide_depth", 0, F_DEP, 4);
        expect_val("t4_wide_eo",    0, F_EO,  0);
        flush();
        send_str("end ");
        expect_val("t4_after_err_depth", 2, F_DEP, 2);
        expect_val("t4_max_no_drop",     2, F_MAX, 3);
        flush();

        // T5: gaps with in_valid=0
        do_reset();
        send_str("be");
        in = 8'h78;
        repeat (3) @(posedge clk);
        #1;
        send_str("gin ");
        expect_val("t5_depth", 0, F_DEP, 1);
        flush();

        // T6: partial word discarded by reset
        do_reset();
        send_str("begi");
        do_reset();
        send_str("n ");
        expect_val("t6_depth",  0, F_DEP, 0);
        expect_val("t6_result", 0, F_RES, 1);
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
